// File: rtl/result_pack_pkg.sv
// result_pack shared definitions
// lane geometry defaults and state encodings
package result_pack_pkg;

    localparam int CONV_GROUP_NUM    = 64;
    localparam int DATA_RESULT_WIDTH = 16;
    localparam int BEAT_W            = 128;
    localparam int GRP               = 8;

    typedef enum logic [3:0] {
        RPACK_IDLE     = 4'd1,
        RPACK_PACK     = 4'd2,
        RPACK_VEC_DONE = 4'd3,
        RPACK_END      = 4'd4
    } rpack_state_e;

endpackage

// File: rtl/result_pack_if.sv
// result_pack bus bundle
// config, per-lane results and packed output beat
interface result_pack_if #(
    parameter int LANES = 64,
    parameter int RW    = 16
);
    logic                  s_config_valid;
    logic                  s_config_ready;
    logic [31:0]           s_config_data;
    logic [LANES-1:0]      s_result_valid;
    logic [LANES-1:0]      s_result_ready;
    logic [RW*LANES-1:0]   s_result_data;
    logic                  m_result_valid;
    logic                  m_result_ready;
    logic [127:0]          m_result_data;
    logic                  m_result_last;

    modport slave (
        input  s_config_valid, s_config_data,
        output s_config_ready,
        input  s_result_valid, s_result_data,
        output s_result_ready,
        output m_result_valid, m_result_data, m_result_last,
        input  m_result_ready
    );

    modport master (
        output s_config_valid, s_config_data,
        input  s_config_ready,
        output s_result_valid, s_result_data,
        input  s_result_ready,
        input  m_result_valid, m_result_data, m_result_last,
        output m_result_ready
    );
endinterface

// File: rtl/result_reg_slice.sv
// result_reg_slice: one-entry valid/ready output register
// accepts a new word while the held one drains (full throughput)
module result_reg_slice #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    input  logic         i_last,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_last
);
    logic         r_valid;
    logic [W-1:0] r_data;
    logic         r_last;

    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_valid && r_last;

    // hold the word until the consumer takes it, reload on accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
                r_last <= i_last;
            end
        end
    end
endmodule

// File: rtl/result_pack.sv
// result_pack: packs 8 result lanes per beat into 128-bit words
// walks all lane groups once per vector, N vectors per config
module result_pack
    import result_pack_pkg::*;
#(
    parameter int LANES = CONV_GROUP_NUM,
    parameter int RW    = DATA_RESULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    result_pack_if.slave  bus,
    output logic [3:0]    status_rpack
);
    localparam int NBEAT = LANES / GRP;
    localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEAT - 1);

    rpack_state_e          r_state;
    rpack_state_e          w_next;
    logic [23:0]           r_n;
    logic [23:0]           r_vec_cnt;
    logic [BW-1:0]         r_beat;

    logic                  w_cfg_ready;
    logic                  w_pack_en;
    logic                  w_cfg_fire;
    logic [BW+2:0]         w_base;
    logic [GRP-1:0]        w_grp_valid;
    logic                  w_slice_ready;
    logic                  w_take;
    logic                  w_beat_last;
    logic                  w_vec_last;
    logic [LANES-1:0]      w_rdy;
    logic [BEAT_W-1:0]     w_pack_data;
    logic                  w_m_valid;
    logic                  w_unused_cfg;

    assign w_unused_cfg = ^bus.s_config_data[31:24];

    assign w_cfg_fire  = bus.s_config_valid && w_cfg_ready;
    assign w_base      = {r_beat, 3'b000};
    assign w_grp_valid = bus.s_result_valid[w_base +: GRP];
    assign w_take      = w_pack_en && (&w_grp_valid) && w_slice_ready;
    assign w_beat_last = (r_beat == LAST_BEAT);
    assign w_vec_last  = (r_vec_cnt == r_n - 24'd1);

    assign bus.s_config_ready = w_cfg_ready;
    assign bus.s_result_ready = w_rdy;
    assign bus.m_result_valid = w_m_valid;
    assign status_rpack       = r_state;

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= RPACK_IDLE;
        else        r_state <= w_next;
    end

    // next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            RPACK_IDLE:
                if (w_cfg_fire)
                    w_next = (bus.s_config_data[23:0] == 24'd0) ?
                             RPACK_END : RPACK_PACK;
            RPACK_PACK:
                if (w_take && w_beat_last) w_next = RPACK_VEC_DONE;
            RPACK_VEC_DONE:
                w_next = (({1'b0, r_vec_cnt} + 25'd1) < {1'b0, r_n}) ?
                         RPACK_PACK : RPACK_END;
            RPACK_END:
                if (!w_m_valid) w_next = RPACK_IDLE;
            default:
                w_next = RPACK_IDLE;
        endcase
    end

    // state-dependent enables, suppressed while reset is asserted
    always_comb begin
        w_cfg_ready = 1'b0;
        w_pack_en   = 1'b0;
        case (r_state)
            RPACK_IDLE: w_cfg_ready = rst_n;
            RPACK_PACK: w_pack_en   = rst_n;
            default:    ;
        endcase
    end

    // pop strobe for the selected lane group on a take
    always_comb begin
        w_rdy = '0;
        if (w_take) w_rdy[w_base +: GRP] = '1;
    end

    // sign-extend each selected lane into its 16-bit slot, lane 0 on top
    always_comb begin
        w_pack_data = '0;
        for (int k = 0; k < GRP; k++) begin
            w_pack_data[BEAT_W-1-16*k -: 16] = 16'($signed(
                bus.s_result_data[(int'(w_base) + k) * RW +: RW]));
        end
    end

    // vector count latch, beat and vector counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_n       <= '0;
            r_vec_cnt <= '0;
            r_beat    <= '0;
        end else if (w_cfg_fire) begin
            r_n       <= bus.s_config_data[23:0];
            r_vec_cnt <= '0;
            r_beat    <= '0;
        end else if (r_state == RPACK_VEC_DONE) begin
            r_vec_cnt <= r_vec_cnt + 24'd1;
            r_beat    <= '0;
        end else if (w_take && !w_beat_last) begin
            r_beat <= r_beat + 1'b1;
        end
    end

    result_reg_slice #(
        .W (BEAT_W)
    ) u_slice (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_take),
        .o_ready (w_slice_ready),
        .i_data  (w_pack_data),
        .i_last  (w_beat_last && w_vec_last),
        .o_valid (w_m_valid),
        .i_ready (bus.m_result_ready),
        .o_data  (bus.m_result_data),
        .o_last  (bus.m_result_last)
    );
endmodule

// File: tb/tb_result_pack.sv
// tb_result_pack: directed vectors for result_pack
// per-lane FWFT sources, beat collector and hand-computed beats
module tb_result_pack;
    localparam int LANES = 64;
    localparam int NB    = LANES / 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] status;
    logic [3:0] status12;

    result_pack_if #(.LANES(LANES), .RW(16)) rif();
    result_pack_if #(.LANES(8), .RW(12))     rif12();

    result_pack #(.LANES(LANES), .RW(16)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (rif),
        .status_rpack (status)
    );

    result_pack #(.LANES(8), .RW(12)) u_dut12 (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (rif12),
        .status_rpack (status12)
    );

    always #5 clk = ~clk;

    int               n_cmp = 0;
    int               n_bad = 0;
    int               cyc = 0;
    int               pops [LANES];
    int               snap [LANES];
    int               base = 0;
    int               stall_err = 0;
    int               rdy_mode = 1;
    logic [LANES-1:0] vmask = '1;
    logic [127:0]     got_d [$];
    logic             got_l [$];
    int               got_c [$];
    logic [127:0]     prev_d = '0;
    bit               prev_stall = 1'b0;

    initial foreach (pops[i]) pops[i] = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // lane i of vector v in this run carries i + 64*(pops so far)
    function automatic logic [127:0] exp_beat(int v, int b);
        logic [127:0] r = '0;
        for (int k = 0; k < 8; k++)
            r[127-16*k -: 16] = 16'(8*b + k + 64*(snap[8*b+k] + v));
        return r;
    endfunction

    // collector: pops, delivered beats and stall stability
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < LANES; i++)
            if (rif.s_result_ready[i] === 1'b1) pops[i]++;
        if (prev_stall && (rif.m_result_valid !== 1'b1 ||
                           rif.m_result_data !== prev_d))
            stall_err++;
        prev_stall = rst_n && rif.m_result_valid === 1'b1 &&
                     rif.m_result_ready !== 1'b1;
        prev_d = rif.m_result_data;
        if (rst_n && rif.m_result_valid === 1'b1 &&
            rif.m_result_ready === 1'b1) begin
            got_d.push_back(rif.m_result_data);
            got_l.push_back(rif.m_result_last);
            got_c.push_back(cyc);
        end
    end

    // lane sources and output-side ready
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < LANES; i++)
            rif.s_result_data[i*16 +: 16] = 16'(i + 64*pops[i]);
        rif.s_result_valid = vmask;
        case (rdy_mode)
            1:       rif.m_result_ready = 1'b1;
            2:       rif.m_result_ready = ~rif.m_result_ready;
            3:       rif.m_result_ready = (got_d.size() - base) < 3;
            default: rif.m_result_ready = 1'b0;
        endcase
    end

    task automatic start_run();
        foreach (snap[i]) snap[i] = pops[i];
        base = got_d.size();
    endtask

    task automatic send_cfg(input logic [31:0] n);
        bit ok = 1'b0;
        @(posedge clk);
        #1;
        rif.s_config_valid = 1'b1;
        rif.s_config_data  = n;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            ok = (rif.s_config_ready === 1'b1);
            @(posedge clk);
            if (ok) break;
        end
        #1 rif.s_config_valid = 1'b0;
        chk("cfg_accept", 128'(ok), 128'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int t = 0; t < 2000 && !ok; t++) begin
            @(negedge clk);
            ok = (status == 4'd1 && rif.m_result_valid === 1'b0);
        end
        chk({tag, "_idle"}, 128'(ok), 128'd1);
    endtask

    task automatic check_run(input string tag, input int nv);
        int bad = 0;
        int lbad = 0;
        int pbad = 0;
        int cnt = got_d.size() - base;
        chk({tag, "_beats"}, 128'(cnt), 128'(nv*NB));
        for (int j = 0; j < nv*NB && j < cnt; j++) begin
            if (got_d[base+j] !== exp_beat(j / NB, j % NB)) bad++;
            if (got_l[base+j] !== (j == nv*NB - 1)) lbad++;
        end
        foreach (pops[i]) if (pops[i] - snap[i] != nv) pbad++;
        chk({tag, "_data"}, 128'(bad), 128'd0);
        chk({tag, "_last"}, 128'(lbad), 128'd0);
        chk({tag, "_pops"}, 128'(pbad), 128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int s0;
        int psum;
        bit ok;
        logic [127:0] d12;
        logic         l12;

        rst_n = 1'b0;
        rif.s_config_valid = 1'b0;
        rif.s_config_data  = '0;
        rif12.s_config_valid = 1'b0;
        rif12.s_config_data  = '0;
        rif12.s_result_valid = '1;
        rif12.s_result_data  = {12'h456, 12'h123, 12'h000, 12'hABC,
                                12'h001, 12'h800, 12'h7FF, 12'hFFF};
        rif12.m_result_ready = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cfg_ready", 128'(rif.s_config_ready), 128'd0);
        chk("rst_res_ready", 128'(rif.s_result_ready), 128'd0);
        chk("rst_m_valid", 128'(rif.m_result_valid), 128'd0);
        chk("rst_m_data", rif.m_result_data, 128'd0);
        chk("rst_m_last", 128'(rif.m_result_last), 128'd0);
        chk("rst_state", 128'(status), 128'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_cfg_ready", 128'(rif.s_config_ready), 128'd1);

        // RW=12 sign extension
        @(posedge clk);
        #1;
        rif12.s_config_valid = 1'b1;
        rif12.s_config_data  = 32'hAB00_0001;
        @(posedge clk);
        #1 rif12.s_config_valid = 1'b0;
        ok = 1'b0;
        d12 = '0;
        l12 = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (rif12.m_result_valid === 1'b1) begin
                ok  = 1'b1;
                d12 = rif12.m_result_data;
                l12 = rif12.m_result_last;
            end
        end
        chk("rw12_seen", 128'(ok), 128'd1);
        chk("rw12_data", d12,
            128'hFFFF_07FF_F800_0001_FABC_0000_0123_0456);
        chk("rw12_last", 128'(l12), 128'd1);

        // N=1, lane i = i, ready held high
        start_run();
        rdy_mode = 1;
        send_cfg(32'd1);
        wait_idle("t1");
        check_run("t1", 1);
        chk("t1_beat0", got_d[base],
            128'h0000_0001_0002_0003_0004_0005_0006_0007);
        chk("t1_beat7", got_d[base+7],
            128'h0038_0039_003A_003B_003C_003D_003E_003F);
        chk("t1_span", 128'(got_c[base+7] - got_c[base]), 128'd7);

        // N=2 with ready toggling
        start_run();
        s0 = stall_err;
        rdy_mode = 2;
        send_cfg(32'd2);
        wait_idle("t2");
        check_run("t2", 2);
        chk("t2_stable", 128'(stall_err - s0), 128'd0);

        // lane 13 late: beat1 waits for it
        start_run();
        rdy_mode = 1;
        vmask[13] = 1'b0;
        send_cfg(32'd1);
        repeat (20) @(negedge clk);
        chk("t3_held_beats", 128'(got_d.size() - base), 128'd1);
        chk("t3_grp1_nopop",
            128'(pops[8] - snap[8] + pops[15] - snap[15]), 128'd0);
        chk("t3_state", 128'(status), 128'd2);
        vmask[13] = 1'b1;
        wait_idle("t3");
        check_run("t3", 1);

        // N=0 goes straight to END
        start_run();
        send_cfg(32'd0);
        @(negedge clk);
        chk("t4_end", 128'(status), 128'd4);
        wait_idle("t4");
        check_run("t4", 0);

        // reset while beat 3 is held
        start_run();
        rdy_mode = 3;
        send_cfg(32'd1);
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = (got_d.size() - base == 3) && rif.m_result_valid === 1'b1;
        end
        chk("t5_reach", 128'(ok), 128'd1);
        repeat (2) @(negedge clk);
        chk("t5_hold", rif.m_result_data, exp_beat(0, 3));
        chk("t5_state", 128'(status), 128'd2);
        psum = 0;
        foreach (pops[i]) psum += pops[i];
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_cfg_ready", 128'(rif.s_config_ready), 128'd0);
        chk("t5_rst_res_ready", 128'(rif.s_result_ready), 128'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_m_valid", 128'(rif.m_result_valid), 128'd0);
        chk("t5_m_data", rif.m_result_data, 128'd0);
        chk("t5_state_idle", 128'(status), 128'd1);
        chk("t5_cfg_ready", 128'(rif.s_config_ready), 128'd1);
        foreach (pops[i]) psum -= pops[i];
        chk("t5_no_pops", 128'(psum), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
